// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected classifier sequencer.
package fc_pkg;

   localparam int unsigned NUM_CLASSES = 4;

   typedef logic [1:0]       class_t;
   typedef logic [7:0]       score_t;
   typedef logic [63:0]      weight_t;
   typedef logic [3:0][7:0]  pixels_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } fc_state_e;

endpackage

// File: rtl/fc_argmax_acc.sv
// Running arg-max over tagged scores; strict greater-than keeps the lowest index on ties.
module fc_argmax_acc
   import fc_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clear,
   input  logic   valid,
   input  class_t tag,
   input  score_t score,
   output class_t best_id,
   output score_t best_score
);

   logic   r_have;
   class_t r_best_id;
   score_t r_best_score;
   logic   w_take;

   // First capture after a clear is taken unconditionally so all-zero scores still win.
   assign w_take = valid && (!r_have || (score > r_best_score));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_have       <= 1'b0;
         r_best_id    <= '0;
         r_best_score <= '0;
      end else if (clear) begin
         r_have       <= 1'b0;
         r_best_id    <= '0;
         r_best_score <= '0;
      end else if (w_take) begin
         r_have       <= 1'b1;
         r_best_id    <= tag;
         r_best_score <= score;
      end
   end

   assign best_id    = r_best_id;
   assign best_score = r_best_score;

endmodule

// File: rtl/fc_sequencer.sv
// Issues one weight word per class to an external FCNeuron and picks the highest-scoring class.
module fc_sequencer
   import fc_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = fc_pkg::NUM_CLASSES,
   parameter int unsigned NRN_LAT     = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    cfg_we,
   input  class_t  cfg_addr,
   input  weight_t cfg_wdata,
   input  logic    start,
   input  pixels_t pixels_in,
   output logic    nrn_valid,
   output weight_t nrn_weight,
   output pixels_t nrn_pixels,
   input  score_t  nrn_result,
   output logic    busy,
   output logic    done,
   output class_t  class_id,
   output score_t  class_score
);

   localparam class_t LastClass = class_t'(NUM_CLASSES - 1);

   fc_state_e          r_state;
   weight_t            r_bank [NUM_CLASSES];
   class_t             r_issue_idx;
   logic [2:0]         r_drain_cnt;
   logic               r_nrn_valid;
   weight_t            r_nrn_weight;
   pixels_t            r_pixels;
   logic               r_busy;
   logic               r_done;
   class_t             r_class_id;
   score_t             r_class_score;
   logic [NRN_LAT-1:0] r_tag_vld;
   class_t             r_tag_id [NRN_LAT];

   logic               w_accept;
   class_t             w_next_idx;
   class_t             w_best_id;
   score_t             w_best_score;

   assign w_accept   = (r_state == StIdle) && start;
   assign w_next_idx = r_issue_idx + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CLASSES; i++) r_bank[i] <= '0;
      end else if (cfg_we && (r_state == StIdle)) begin
         r_bank[cfg_addr] <= cfg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_issue_idx   <= '0;
         r_drain_cnt   <= '0;
         r_nrn_valid   <= 1'b0;
         r_nrn_weight  <= '0;
         r_pixels      <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_class_id    <= '0;
         r_class_score <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_state      <= StIssue;
                  r_pixels     <= pixels_in;
                  r_issue_idx  <= '0;
                  r_nrn_valid  <= 1'b1;
                  r_nrn_weight <= r_bank[0];
                  r_busy       <= 1'b1;
               end
            end
            StIssue: begin
               if (r_issue_idx == LastClass) begin
                  r_state      <= StDrain;
                  r_nrn_valid  <= 1'b0;
                  r_nrn_weight <= '0;
                  r_drain_cnt  <= '0;
               end else begin
                  r_issue_idx  <= w_next_idx;
                  r_nrn_weight <= r_bank[w_next_idx];
               end
            end
            StDrain: begin
               if (r_drain_cnt == 3'(NRN_LAT - 1)) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 3'd1;
               end
            end
            StDone: begin
               r_state       <= StIdle;
               r_done        <= 1'b0;
               r_busy        <= 1'b0;
               r_class_id    <= w_best_id;
               r_class_score <= w_best_score;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Stage NRN_LAT-1 lines up with the cycle nrn_result belongs to the tagged class.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld <= '0;
         for (int i = 0; i < NRN_LAT; i++) r_tag_id[i] <= '0;
      end else begin
         r_tag_vld[0] <= r_nrn_valid;
         r_tag_id[0]  <= r_issue_idx;
         for (int i = 1; i < NRN_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
         end
      end
   end

   fc_argmax_acc u_argmax (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (w_accept),
      .valid      (r_tag_vld[NRN_LAT-1]),
      .tag        (r_tag_id[NRN_LAT-1]),
      .score      (nrn_result),
      .best_id    (w_best_id),
      .best_score (w_best_score)
   );

   assign nrn_valid   = r_nrn_valid;
   assign nrn_weight  = r_nrn_weight;
   assign nrn_pixels  = r_pixels;
   assign busy        = r_busy;
   assign done        = r_done;
   // The accumulator is final during DONE; afterwards the held copy is presented.
   assign class_id    = r_done ? w_best_id : r_class_id;
   assign class_score = r_done ? w_best_score : r_class_score;

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer with an NRN_LAT-delayed FCNeuron lookup model.
module tb_fc_sequencer;
   import fc_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n = 1'b0;
   logic    cfg_we = 1'b0;
   class_t  cfg_addr = '0;
   weight_t cfg_wdata = '0;
   logic    start = 1'b0;
   logic    start3 = 1'b0;
   pixels_t pixels_in = '0;

   logic    nrn_valid, busy, done;
   weight_t nrn_weight;
   pixels_t nrn_pixels;
   score_t  nrn_result, class_score;
   class_t  class_id;

   logic    nrn_valid3, busy3, done3;
   weight_t nrn_weight3;
   pixels_t nrn_pixels3;
   score_t  nrn_result3, class_score3;
   class_t  class_id3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fc_sequencer #(.NUM_CLASSES(4), .NRN_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .pixels_in(pixels_in), .nrn_valid(nrn_valid), .nrn_weight(nrn_weight),
      .nrn_pixels(nrn_pixels), .nrn_result(nrn_result), .busy(busy), .done(done),
      .class_id(class_id), .class_score(class_score)
   );

   fc_sequencer #(.NUM_CLASSES(4), .NRN_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start3), .pixels_in(pixels_in), .nrn_valid(nrn_valid3), .nrn_weight(nrn_weight3),
      .nrn_pixels(nrn_pixels3), .nrn_result(nrn_result3), .busy(busy3), .done(done3),
      .class_id(class_id3), .class_score(class_score3)
   );

   // FCNeuron model: class = issue position; result appears NRN_LAT cycles later.
   // Untagged cycles drive 0xFF so a mistimed capture would win the arg-max.
   score_t     scores [4];
   score_t     scores3 [4];
   class_t     cnt = '0;
   class_t     cnt3 = '0;
   logic       pv = 1'b0;
   score_t     ps = '0;
   logic [2:0] pv3 = '0;
   score_t     ps3 [3];

   always @(posedge clk) begin
      cnt    <= nrn_valid ? class_t'(cnt + 2'd1) : '0;
      pv     <= nrn_valid;
      ps     <= scores[cnt];
      cnt3   <= nrn_valid3 ? class_t'(cnt3 + 2'd1) : '0;
      pv3    <= {pv3[1:0], nrn_valid3};
      ps3[0] <= scores3[cnt3];
      ps3[1] <= ps3[0];
      ps3[2] <= ps3[1];
   end

   assign nrn_result  = pv ? ps : 8'hFF;
   assign nrn_result3 = pv3[2] ? ps3[2] : 8'hFF;

   function automatic weight_t wexp(input int k);
      return 64'h0101_0101_0101_0101 * 64'(k + 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_weights();
      for (int k = 0; k < 4; k++) begin
         cfg_we = 1'b1; cfg_addr = class_t'(k); cfg_wdata = wexp(k);
         tick();
      end
      cfg_we = 1'b0;
   endtask

   // Pulses start; returns the cycle done rose (start edge = cycle 0), or -1 on timeout.
   task automatic run_op(input bit sel, input pixels_t pix, output int dcyc, output class_t id,
                         output score_t sc);
      dcyc = -1; id = '0; sc = '0;
      pixels_in = pix;
      if (sel) start3 = 1'b1; else start = 1'b1;
      tick();
      start = 1'b0; start3 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if ((sel ? done3 : done) === 1'b1) begin
            dcyc = c;
            id   = sel ? class_id3 : class_id;
            sc   = sel ? class_score3 : class_score;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0h exp=0", done); end
      n_vec++; if (nrn_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h exp=0", nrn_valid); end
      n_vec++; if (nrn_weight !== 64'h0) begin n_err++; $display("FAIL reset_weight got=%0h exp=0", nrn_weight); end
      n_vec++; if (nrn_pixels !== 32'h0) begin n_err++; $display("FAIL reset_pixels got=%0h exp=0", nrn_pixels); end
      n_vec++; if (class_id !== 2'd0) begin n_err++; $display("FAIL reset_id got=%0h exp=0", class_id); end
      n_vec++; if (class_score !== 8'd0) begin n_err++; $display("FAIL reset_score got=%0h exp=0", class_score); end
      n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL reset_busy3 got=%0h exp=0", busy3); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_issue_stream();
      logic    exp_v, exp_d;
      weight_t exp_w;
      scores = '{8'd20, 8'd90, 8'd40, 8'd90};
      pixels_in = 32'h1020_3040;
      start = 1'b1;
      tick();
      start = 1'b0;
      pixels_in = 32'hFFFF_FFFF;
      for (int c = 1; c <= 7; c++) begin
         exp_v = (c <= 4);
         exp_w = (c <= 4) ? wexp(c - 1) : 64'h0;
         exp_d = (c == 6);
         n_vec++; if (nrn_valid !== exp_v) begin n_err++;
            $display("FAIL issue_valid c=%0d got=%0h exp=%0h", c, nrn_valid, exp_v); end
         n_vec++; if (nrn_weight !== exp_w) begin n_err++;
            $display("FAIL issue_weight c=%0d got=%0h exp=%0h", c, nrn_weight, exp_w); end
         n_vec++; if (nrn_pixels !== 32'h1020_3040) begin n_err++;
            $display("FAIL issue_pixels c=%0d got=%0h exp=10203040", c, nrn_pixels); end
         n_vec++; if (done !== exp_d) begin n_err++;
            $display("FAIL issue_done c=%0d got=%0h exp=%0h", c, done, exp_d); end
         if (c <= 5) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL issue_busy c=%0d got=%0h exp=1", c, busy); end
         end
         if (c >= 6) begin
            n_vec++; if (class_id !== 2'd1) begin n_err++;
               $display("FAIL issue_id c=%0d got=%0d exp=1", c, class_id); end
            n_vec++; if (class_score !== 8'd90) begin n_err++;
               $display("FAIL issue_score c=%0d got=%0d exp=90", c, class_score); end
         end
         if (c == 7) begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL issue_idle_busy got=%0h exp=0", busy); end
         end
         tick();
      end
   endtask

   task automatic test_zero_then_max();
      int dc; class_t id; score_t sc;
      scores = '{8'd0, 8'd0, 8'd0, 8'd0};
      run_op(1'b0, 32'hA5A5_A5A5, dc, id, sc);
      n_vec++; if (dc !== 6) begin n_err++; $display("FAIL zero_latency got=%0d exp=6", dc); end
      n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL zero_id got=%0d exp=0", id); end
      n_vec++; if (sc !== 8'd0) begin n_err++; $display("FAIL zero_score got=%0d exp=0", sc); end
      scores = '{8'd5, 8'd6, 8'd7, 8'd255};
      run_op(1'b0, 32'h0102_0304, dc, id, sc);
      n_vec++; if (dc !== 6) begin n_err++; $display("FAIL max_latency got=%0d exp=6", dc); end
      n_vec++; if (id !== 2'd3) begin n_err++; $display("FAIL max_id got=%0d exp=3", id); end
      n_vec++; if (sc !== 8'd255) begin n_err++; $display("FAIL max_score got=%0d exp=255", sc); end
   endtask

   task automatic test_back_to_back();
      int dc;
      scores = '{8'd20, 8'd90, 8'd40, 8'd90};
      pixels_in = 32'h1122_3344;
      start = 1'b1;
      tick();                                     // cycle 1
      start = 1'b0;
      tick();                                     // cycle 2
      start = 1'b1; pixels_in = 32'hCAFE_F00D;
      tick();                                     // cycle 3
      start = 1'b0;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();                                     // cycle 4
      cfg_we = 1'b0;
      dc = -1;
      for (int c = 4; c <= 20; c++) begin
         if (done === 1'b1) begin dc = c; break; end
         tick();
      end
      n_vec++; if (dc !== 6) begin n_err++; $display("FAIL b2b_latency got=%0d exp=6", dc); end
      n_vec++; if (class_id !== 2'd1) begin n_err++; $display("FAIL b2b_id got=%0d exp=1", class_id); end
      n_vec++; if (class_score !== 8'd90) begin n_err++;
         $display("FAIL b2b_score got=%0d exp=90", class_score); end
      n_vec++; if (nrn_pixels !== 32'h1122_3344) begin n_err++;
         $display("FAIL b2b_pixels got=%0h exp=11223344", nrn_pixels); end
      // Start raised in the DONE cycle must be ignored, then accepted in the first IDLE cycle.
      start = 1'b1; pixels_in = 32'h5566_7788;
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL done_start_busy got=%0h exp=0", busy); end
      tick();
      start = 1'b0;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL idle_start_busy got=%0h exp=1", busy); end
      n_vec++; if (nrn_weight !== wexp(0)) begin n_err++;
         $display("FAIL w0_unchanged got=%0h exp=%0h", nrn_weight, wexp(0)); end
      n_vec++; if (nrn_pixels !== 32'h5566_7788) begin n_err++;
         $display("FAIL relatch_pixels got=%0h exp=55667788", nrn_pixels); end
      dc = -1;
      for (int c = 1; c <= 20; c++) begin
         if (done === 1'b1) begin dc = c; break; end
         tick();
      end
      n_vec++; if (dc !== 6) begin n_err++; $display("FAIL b2b2_latency got=%0d exp=6", dc); end
      tick();
   endtask

   task automatic test_reset_abort();
      int dc; class_t id; score_t sc; bit saw_done;
      scores = '{8'd20, 8'd90, 8'd40, 8'd90};
      pixels_in = 32'h0A0B_0C0D;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();                                     // cycle 3 of ISSUE
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%0h exp=0", busy); end
      n_vec++; if (nrn_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got=%0h exp=0", nrn_valid); end
      n_vec++; if (class_id !== 2'd0) begin n_err++; $display("FAIL abort_id got=%0d exp=0", class_id); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (done !== 1'b0) saw_done = 1'b1;
         tick();
      end
      n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%0h exp=0", saw_done); end
      load_weights();
      scores = '{8'd30, 8'd10, 8'd50, 8'd50};
      run_op(1'b0, 32'h0A0B_0C0D, dc, id, sc);
      n_vec++; if (dc !== 6) begin n_err++; $display("FAIL post_reset_latency got=%0d exp=6", dc); end
      n_vec++; if (id !== 2'd2) begin n_err++; $display("FAIL post_reset_id got=%0d exp=2", id); end
      n_vec++; if (sc !== 8'd50) begin n_err++; $display("FAIL post_reset_score got=%0d exp=50", sc); end
   endtask

   task automatic test_lat3();
      int dc; class_t id; score_t sc;
      scores3 = '{8'd1, 8'd2, 8'd3, 8'd4};
      run_op(1'b1, 32'h0405_0607, dc, id, sc);
      n_vec++; if (dc !== 8) begin n_err++; $display("FAIL lat3_latency got=%0d exp=8", dc); end
      n_vec++; if (id !== 2'd3) begin n_err++; $display("FAIL lat3_id got=%0d exp=3", id); end
      n_vec++; if (sc !== 8'd4) begin n_err++; $display("FAIL lat3_score got=%0d exp=4", sc); end
   endtask

   initial begin
      scores  = '{8'd0, 8'd0, 8'd0, 8'd0};
      scores3 = '{8'd0, 8'd0, 8'd0, 8'd0};
      ps3     = '{8'd0, 8'd0, 8'd0};
      test_reset();
      load_weights();
      test_issue_stream();
      test_zero_then_max();
      test_back_to_back();
      test_reset_abort();
      test_lat3();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameter NUM_CLASSES, default 4: number of output classes (X, O, /, \); fixed at 4 for this release.
REQ-002 Parameter NRN_LAT, default 1: FCNeuron latency in clk cycles, from nrn_valid to nrn_result valid; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cfg_we  input  1  weight-bank write strobe.
REQ-006 cfg_addr  input  2  class index of the weight word to write.
REQ-007 cfg_wdata  input  64  weight word for that class.
REQ-008 start  input  1  single-cycle request to classify pixels_in.
REQ-009 pixels_in  input  32  four 8-bit pooled pixels; sampled only when start is accepted.
REQ-010 nrn_valid  output  1  issue strobe to FCNeuron.
REQ-011 nrn_weight  output  64  weight word for the class being issued.
REQ-012 nrn_pixels  output  32  latched pooled pixels.
REQ-013 nrn_result  input  8  FCNeuron score, unsigned.
REQ-014 busy  output  1  high from the cycle after start acceptance until done.
REQ-015 done  output  1  single-cycle pulse; class_id and class_score are valid in the same cycle.
REQ-016 class_id  output  2  index of the winning class.
REQ-017 class_score  output  8  score of the winning class.

Function
REQ-018 Weight bank SHALL hold NUM_CLASSES x 64-bit words; a cfg_we write SHALL take effect on the next edge, and only in IDLE.
REQ-019 cfg_we asserted while busy SHALL be ignored; the bank is left unchanged.
REQ-020 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-021 On acceptance, pixels_in SHALL be latched into nrn_pixels, which SHALL hold until the next acceptance.
REQ-022 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE:
- IDLE to ISSUE on accepted start.
- ISSUE lasts exactly NUM_CLASSES cycles, then goes to DRAIN.
- DRAIN lasts NRN_LAT cycles, then goes to DONE.
- DONE lasts 1 cycle, then goes to IDLE.
REQ-023 In ISSUE cycle k (k = 0..3), nrn_valid SHALL be 1 and nrn_weight SHALL be W[k]; this issues back-to-back, one class per cycle.
REQ-024 A NRN_LAT-deep valid/tag shift register SHALL mark the cycle in which nrn_result belongs to class k; that result SHALL be captured in exactly that cycle.
REQ-025 The running max SHALL update only when score > current max; ties therefore resolve to the lowest class index.
REQ-026 The first captured result SHALL initialise the running max unconditionally, so an all-zero score vector yields class 0 with score 0.
REQ-027 Latency: if start is sampled at edge 0, done SHALL be high in cycle NUM_CLASSES + NRN_LAT + 1; with defaults, that is cycle 6.
REQ-028 class_id and class_score SHALL hold their values after done until the next done.
REQ-029 nrn_valid SHALL be 0 outside ISSUE, and nrn_weight SHALL be 0 outside ISSUE.
REQ-030 A start in the DONE cycle SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-031 rst_n low SHALL immediately force:
- FSM to IDLE;
- busy, done and nrn_valid to 0;
- nrn_weight, nrn_pixels, class_id and class_score to 0;
- weight bank, tag pipeline and running max cleared.
REQ-032 Reset during ISSUE or DRAIN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-033 Package fc_pkg SHALL hold:
- NUM_CLASSES;
- class_t (2-bit);
- score_t (8-bit);
- weight_t (64-bit);
- pixels_t (4x8 packed);
- the FSM state enum.
REQ-034 The running-max compare/hold logic SHALL live in one sub-module, fc_argmax_acc, with inputs clear, valid, tag and score, and outputs best_id and best_score.
REQ-035 The weight bank, FSM and tag pipeline SHALL remain in fc_sequencer.

Verification
REQ-036 Bench SHALL model FCNeuron as a NRN_LAT-delayed lookup of the issued class.
REQ-037 Scenario: load W[k] = 64'h0101_0101_0101_0101 * (k+1); start with pixels_in = 32'h10203040 -> nrn_valid high for 4 cycles with nrn_weight = W[0]..W[3] in order, and nrn_pixels = 32'h10203040.
REQ-038 Scenario: model scores {20, 90, 40, 90}, defaults -> done in cycle 6, class_id = 1, class_score = 90.
REQ-039 Scenario: scores {0, 0, 0, 0} -> class_id = 0, class_score = 0; then scores {5, 6, 7, 255} -> class_id = 3, class_score = 255.
REQ-040 Scenario: start pulsed again in cycle 2, plus cfg_we to address 0 in cycle 3 -> both ignored; the result matches the single run, and W[0] is unchanged.
REQ-041 Scenario: rst_n low in cycle 3 of ISSUE -> busy and nrn_valid go to 0 asynchronously; no done pulse follows; the next start completes with correct result.
REQ-042 Scenario: NRN_LAT = 3 with scores {1, 2, 3, 4} -> done in cycle 8, class_id = 3.
